// File: rtl/timetag_cmd_pkg.sv
// ---------------------------------------------------------------------------
// timetag_cmd_pkg
// Shared definitions for the timetag command parser: frame sync marker,
// parser state encoding, opcode map and small helper functions.
// ---------------------------------------------------------------------------
package timetag_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_C = 8'hAA;

  // Opcodes understood by the downstream register/control logic
  localparam logic [7:0] OP_CHAN_CTRL = 8'h01;
  localparam logic [7:0] OP_SEQ_CTRL  = 8'h02;
  localparam logic [7:0] OP_REG_WRITE = 8'h04;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_OPCODE  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_ISSUE   = 3'd5
  } state_e;

  // Number of bits needed to hold values 0..max_val (minimum 1)
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) <= max_val) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // Saturating 8-bit increment used for the error counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/timetag_cmd_timeout.sv
// ---------------------------------------------------------------------------
// timetag_cmd_timeout
// Idle counter for the command parser. Counts cycles while run_i is high,
// is reloaded to zero by clr_i (which has priority), and pulses expire_o on
// the TIMEOUT-th consecutive counted cycle, reloading to zero at that point.
//
// Ports:
//   clk       parser clock
//   reset_n   asynchronous active-low reset
//   clr_i     reload counter to zero (byte accepted / not inside a frame)
//   run_i     count this cycle
//   expire_o  one-cycle pulse: idle limit reached this cycle
// ---------------------------------------------------------------------------
import timetag_cmd_pkg::*;

module timetag_cmd_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int             CNT_W    = cnt_width(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count and expire pulse
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        expire_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timetag_cmd_parser.sv
// ---------------------------------------------------------------------------
// timetag_cmd_parser
// Hunts for framed commands (SYNC, LEN, OPCODE, LEN payload bytes, and an
// optional XOR checksum) in the FX2 OUT byte stream and presents each valid
// frame as one opcode+payload transaction on a valid/ready handshake.
// Malformed frames (bad length, idle timeout, bad checksum) bump a
// saturating error counter; garbage between frames is dropped silently.
//
// Optional feature: define TIMETAG_CMD_CSUM_EN to require a checksum byte
// (XOR of LEN, OPCODE and all payload bytes) after the payload.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_data/in_valid      incoming byte stream
//   in_ready              byte accepted this cycle when high with in_valid
//   cmd_valid/cmd_ready   command handshake
//   cmd_opcode/cmd_len    opcode and payload byte count of the command
//   cmd_payload           payload, byte 0 in [7:0], unused bytes zero
//   err_count             saturating count of rejected frames
//   busy                  high whenever the parser is not hunting
// ---------------------------------------------------------------------------
import timetag_cmd_pkg::*;

module timetag_cmd_parser #(
  parameter int         MAX_LEN   = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_C,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_opcode,
  output logic [4:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic [7:0]           err_count,
  output logic                 busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e               state_q, state_d;
  logic [4:0]           len_q, len_d;
  logic [4:0]           idx_q, idx_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [8*MAX_LEN-1:0] payload_q, payload_d;
  logic [7:0]           err_q, err_d;
`ifdef TIMETAG_CMD_CSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic accept_s;
  logic timed_s;
  logic expire_s;

  // A byte is never taken while a command waits for the consumer
  assign in_ready  = (state_q != ST_ISSUE);
  assign accept_s  = in_valid & in_ready;
  assign cmd_valid = (state_q == ST_ISSUE);
  assign busy      = (state_q != ST_HUNT);

  assign cmd_opcode  = opcode_q;
  assign cmd_len     = len_q;
  assign cmd_payload = payload_q;
  assign err_count   = err_q;

  // Idle timeout only runs inside a partially received frame
  assign timed_s = (state_q == ST_LEN) || (state_q == ST_OPCODE) ||
                   (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

  timetag_cmd_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (accept_s | ~timed_s),
    .run_i    (timed_s),
    .expire_o (expire_s)
  );

  // Next-state and datapath update for the frame parser
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    opcode_d  = opcode_q;
    payload_d = payload_q;
    err_d     = err_q;
`ifdef TIMETAG_CMD_CSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (accept_s && (in_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_LEN: begin
        if (expire_s) begin
          err_d   = sat_inc8(err_q);
          state_d = ST_HUNT;
        end else if (accept_s) begin
          if ((in_data == 8'd0) || (in_data > MAX_LEN_B)) begin
            err_d   = sat_inc8(err_q);
            state_d = ST_HUNT;
          end else begin
            len_d     = in_data[4:0];
            idx_d     = 5'd0;
            payload_d = '0;
`ifdef TIMETAG_CMD_CSUM_EN
            csum_d    = in_data;
`endif
            state_d   = ST_OPCODE;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_OPCODE: begin
        if (expire_s) begin
          err_d   = sat_inc8(err_q);
          state_d = ST_HUNT;
        end else if (accept_s) begin
          opcode_d = in_data;
`ifdef TIMETAG_CMD_CSUM_EN
          csum_d   = csum_q ^ in_data;
`endif
          state_d  = ST_PAYLOAD;
        end else begin
          state_d = ST_OPCODE;
        end
      end
      ST_PAYLOAD: begin
        if (expire_s) begin
          err_d   = sat_inc8(err_q);
          state_d = ST_HUNT;
        end else if (accept_s) begin
          // SYNC inside the payload is ordinary data
          payload_d[{idx_q, 3'b000} +: 8] = in_data;
          idx_d = idx_q + 5'd1;
`ifdef TIMETAG_CMD_CSUM_EN
          csum_d = csum_q ^ in_data;
          if (idx_q == (len_q - 5'd1)) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_PAYLOAD;
          end
`else
          if (idx_q == (len_q - 5'd1)) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_PAYLOAD;
          end
`endif
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
`ifdef TIMETAG_CMD_CSUM_EN
      ST_CSUM: begin
        if (expire_s) begin
          err_d   = sat_inc8(err_q);
          state_d = ST_HUNT;
        end else if (accept_s) begin
          if (in_data == csum_q) begin
            state_d = ST_ISSUE;
          end else begin
            err_d   = sat_inc8(err_q);
            state_d = ST_HUNT;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d = ST_HUNT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // Parser state and command registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_HUNT;
      len_q     <= 5'd0;
      idx_q     <= 5'd0;
      opcode_q  <= 8'd0;
      payload_q <= '0;
      err_q     <= 8'd0;
`ifdef TIMETAG_CMD_CSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      opcode_q  <= opcode_d;
      payload_q <= payload_d;
      err_q     <= err_d;
`ifdef TIMETAG_CMD_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_timetag_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_timetag_cmd_parser
// Directed self-checking bench for timetag_cmd_parser (MAX_LEN=8,
// SYNC=AA, TIMEOUT=1024). Frames sent with send_frame carry a checksum
// byte automatically when TIMETAG_CMD_CSUM_EN is defined.
// ---------------------------------------------------------------------------
import timetag_cmd_pkg::*;

module tb_timetag_cmd_parser;

  localparam int MAX_LEN = 8;
  localparam int TIMEOUT = 1024;

  logic                 clk;
  logic                 reset_n;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_opcode;
  logic [4:0]           cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic [7:0]           err_count;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  timetag_cmd_parser #(
    .MAX_LEN   (MAX_LEN),
    .SYNC_BYTE (8'hAA),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .err_count   (err_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One byte, accepted on the next rising edge; returns 1 time unit after it
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] op, input logic [63:0] pl);
    logic [7:0] cs;
    send_byte(8'hAA);
    send_byte(len);
    cs = len;
    send_byte(op);
    cs = cs ^ op;
    check_val("no_early_valid", {63'd0, cmd_valid}, 64'd0);
    for (int i = 0; i < int'(len); i++) begin
      send_byte(pl[i*8 +: 8]);
      cs = cs ^ pl[i*8 +: 8];
    end
`ifdef TIMETAG_CMD_CSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic accept_cmd();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    check_val("valid_drop", {63'd0, cmd_valid}, 64'd0);
    check_val("busy_after_issue", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] op, input logic [4:0] len,
                           input logic [63:0] pl, input logic [7:0] err);
    check_val({tag, "_valid"},   {63'd0, cmd_valid}, 64'd1);
    check_val({tag, "_inready"}, {63'd0, in_ready},  64'd0);
    check_val({tag, "_opcode"},  {56'd0, cmd_opcode}, {56'd0, op});
    check_val({tag, "_len"},     {59'd0, cmd_len},   {59'd0, len});
    check_val({tag, "_payload"}, cmd_payload, pl);
    check_val({tag, "_err"},     {56'd0, err_count}, {56'd0, err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    cmd_ready = 1'b0;
    #12;
    check_val("rst_valid",   {63'd0, cmd_valid}, 64'd0);
    check_val("rst_inready", {63'd0, in_ready},  64'd1);
    check_val("rst_busy",    {63'd0, busy},      64'd0);
    check_val("rst_err",     {56'd0, err_count}, 64'd0);
    check_val("rst_opcode",  {56'd0, cmd_opcode}, 64'd0);
    check_val("rst_len",     {59'd0, cmd_len},   64'd0);
    check_val("rst_payload", cmd_payload,        64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Garbage is dropped silently, then a minimal frame
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hFF);
      check_val("garbage_valid", {63'd0, cmd_valid}, 64'd0);
      check_val("garbage_busy",  {63'd0, busy},      64'd0);
    end
    send_frame(8'd1, OP_SEQ_CTRL, 64'h01);
    check_cmd("garbage_frame", 8'h02, 5'd1, 64'h01, 8'd0);
    accept_cmd();

    // Maximum length frame, consumer stalls while a byte is offered
    send_frame(8'd8, OP_REG_WRITE, 64'h0002_4000_0000_0000);
    check_cmd("max_frame", 8'h04, 5'd8, 64'h0002_4000_0000_0000, 8'd0);
    @(negedge clk);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("stall_valid",   {63'd0, cmd_valid}, 64'd1);
      check_val("stall_inready", {63'd0, in_ready},  64'd0);
      check_val("stall_payload", cmd_payload, 64'h0002_4000_0000_0000);
    end
    @(negedge clk);
    in_valid = 1'b0;
    accept_cmd();

    // Bad lengths: zero and one past the maximum
    send_byte(8'hAA);
    send_byte(8'h00);
    check_val("len0_err",  {56'd0, err_count}, 64'd1);
    check_val("len0_busy", {63'd0, busy},      64'd0);
    send_byte(8'hAA);
    send_byte(8'h09);
    check_val("len9_err",   {56'd0, err_count}, 64'd2);
    check_val("len9_valid", {63'd0, cmd_valid}, 64'd0);
    send_frame(8'd1, OP_CHAN_CTRL, 64'h02);
    check_cmd("after_badlen", 8'h01, 5'd1, 64'h02, 8'd2);
    accept_cmd();

    // Idle timeout inside the payload
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h11);
    check_val("to_busy_start", {63'd0, busy}, 64'd1);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check_val("to_busy_before", {63'd0, busy},      64'd1);
    check_val("to_err_before",  {56'd0, err_count}, 64'd2);
    @(posedge clk);
    #1;
    check_val("to_busy_after", {63'd0, busy},      64'd0);
    check_val("to_err_after",  {56'd0, err_count}, 64'd3);
    check_val("to_valid",      {63'd0, cmd_valid}, 64'd0);
    send_frame(8'd2, OP_SEQ_CTRL, 64'hBEEF);
    check_cmd("after_timeout", 8'h02, 5'd2, 64'hBEEF, 8'd3);
    accept_cmd();

    // Asynchronous reset in the middle of the payload
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h55);
    check_val("mid_busy", {63'd0, busy}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_busy",    {63'd0, busy},       64'd0);
    check_val("arst_inready", {63'd0, in_ready},   64'd1);
    check_val("arst_valid",   {63'd0, cmd_valid},  64'd0);
    check_val("arst_err",     {56'd0, err_count},  64'd0);
    check_val("arst_opcode",  {56'd0, cmd_opcode}, 64'd0);
    check_val("arst_len",     {59'd0, cmd_len},    64'd0);
    check_val("arst_payload", cmd_payload,         64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    // Payload byte 1 equals SYNC and must be taken as data
    send_frame(8'd2, OP_REG_WRITE, 64'hAA12);
    check_cmd("after_reset", 8'h04, 5'd2, 64'hAA12, 8'd0);
    accept_cmd();

`ifdef TIMETAG_CMD_CSUM_EN
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    check_cmd("csum_good", 8'h02, 5'd1, 64'h01, 8'd0);
    accept_cmd();
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h03);
    check_val("csum_bad_valid", {63'd0, cmd_valid}, 64'd0);
    check_val("csum_bad_err",   {56'd0, err_count}, 64'd1);
    check_val("csum_bad_busy",  {63'd0, busy},      64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
